// File: rtl/input_conditioner_pkg.sv
// Shared definitions for the calculator input front-end: debouncer state
// encodings and default sizing.
package input_conditioner_pkg;

  localparam int unsigned DEF_DEBOUNCE_CYCLES = 50000;
  localparam int unsigned DEF_SYNC_STAGES     = 2;
  localparam int unsigned DEF_SW_WIDTH        = 12;

  typedef enum logic [1:0] {
    DB_RELEASED  = 2'b00,
    DB_ARMING    = 2'b01,
    DB_PRESSED   = 2'b10,
    DB_DISARMING = 2'b11
  } db_state_e;

endpackage

// File: rtl/debounce_button.sv
// One pushbutton: polarity normalise, synchronise, debounce. Emits the debounced
// level and a one-cycle rise flag on each accepted press.
module debounce_button
  import input_conditioner_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int unsigned ACTIVE_LOW      = 1
) (
  input  logic clock,
  input  logic Reset_n,
  input  logic raw,
  output logic level,
  output logic rise
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic                   pressed_raw;
  logic                   sync_lvl;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [SYNC_STAGES-1:0] fill_q, fill_d;
  logic                   ready_q, ready_d;
  db_state_e              state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d, cnt_inc;
  logic                   level_q, level_d;
  logic                   rise_q, rise_d;

  assign pressed_raw = (ACTIVE_LOW != 0) ? ~raw : raw;
  assign sync_lvl    = sync_q[SYNC_STAGES-1];
  assign cnt_inc     = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);

  // A button held through reset must be seen released once (after the
  // synchroniser has refilled) before any press is accepted.
  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], pressed_raw};
    fill_d  = {fill_q[SYNC_STAGES-2:0], 1'b1};
    ready_d = ready_q | (fill_q[SYNC_STAGES-1] & ~sync_lvl);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rise_d  = 1'b0;
    case (state_q)
      DB_RELEASED: begin
        cnt_d = '0;
        if (ready_q && sync_lvl) begin
          state_d = DB_ARMING;
          cnt_d   = CNT_W'(1);
        end
      end
      DB_ARMING: begin
        if (!sync_lvl) begin
          state_d = DB_RELEASED;
          cnt_d   = '0;
        end else if (cnt_q >= CNT_LAST) begin
          state_d = DB_PRESSED;
          cnt_d   = '0;
          rise_d  = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      DB_PRESSED: begin
        cnt_d = '0;
        if (!sync_lvl) begin
          state_d = DB_DISARMING;
          cnt_d   = CNT_W'(1);
        end
      end
      DB_DISARMING: begin
        if (sync_lvl) begin
          state_d = DB_PRESSED;
          cnt_d   = '0;
        end else if (cnt_q >= CNT_LAST) begin
          state_d = DB_RELEASED;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: begin
        state_d = DB_RELEASED;
        cnt_d   = '0;
      end
    endcase
    level_d = (state_d == DB_PRESSED) || (state_d == DB_DISARMING);
  end

  always_ff @(posedge clock or negedge Reset_n) begin
    if (!Reset_n) begin
      sync_q  <= '0;
      fill_q  <= '0;
      ready_q <= 1'b0;
      state_q <= DB_RELEASED;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      fill_q  <= fill_d;
      ready_q <= ready_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
    end
  end

  assign level = level_q;
  assign rise  = rise_q;

endmodule

// File: rtl/input_conditioner.sv
// Calculator input front-end: debounced Enter/Clear strobes and a switch word
// that is guaranteed stable whenever EnterPulse is high.
module input_conditioner
  import input_conditioner_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int unsigned BTN_ACTIVE_LOW  = 1,
  parameter int unsigned SW_WIDTH        = DEF_SW_WIDTH
) (
  input  logic                clock,
  input  logic                Reset_n,
  input  logic                EnterRaw,
  input  logic                ClearRaw,
  input  logic [SW_WIDTH-1:0] SwitchsRaw,
  output logic                EnterPulse,
  output logic                ClearPulse,
  output logic [SW_WIDTH-1:0] SwitchsOut,
  output logic                SwitchsStable,
  output logic                BusyLed
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

  logic enter_level, enter_rise;
  logic clear_level, clear_rise;

  logic [SYNC_STAGES-1:0][SW_WIDTH-1:0] sw_sync_q, sw_sync_d;
  logic [SW_WIDTH-1:0] sw_now;
  logic [SW_WIDTH-1:0] sw_last_q, sw_last_d;
  logic [CNT_W-1:0]    sw_cnt_q, sw_cnt_d;
  logic                sw_stable_q, sw_stable_d;
  logic [SW_WIDTH-1:0] sw_deb_q, sw_deb_d;

  logic                pending_q, pending_d;
  logic                enter_pulse_q, enter_pulse_d;
  logic                clear_pulse_q, clear_pulse_d;
  logic [SW_WIDTH-1:0] sw_out_q, sw_out_d;
  logic                busy_q, busy_d;

  debounce_button #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .SYNC_STAGES    (SYNC_STAGES),
    .ACTIVE_LOW     (BTN_ACTIVE_LOW)
  ) u_enter (
    .clock  (clock),
    .Reset_n(Reset_n),
    .raw    (EnterRaw),
    .level  (enter_level),
    .rise   (enter_rise)
  );

  debounce_button #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .SYNC_STAGES    (SYNC_STAGES),
    .ACTIVE_LOW     (BTN_ACTIVE_LOW)
  ) u_clear (
    .clock  (clock),
    .Reset_n(Reset_n),
    .raw    (ClearRaw),
    .level  (clear_level),
    .rise   (clear_rise)
  );

  assign sw_now = sw_sync_q[SYNC_STAGES-1];

  // Switch stabiliser: any change restarts the shared counter.
  always_comb begin
    sw_sync_d[0] = SwitchsRaw;
    for (int i = 1; i < int'(SYNC_STAGES); i++) begin
      sw_sync_d[i] = sw_sync_q[i-1];
    end
    sw_last_d = sw_now;
    sw_cnt_d  = sw_cnt_q;
    if (sw_now != sw_last_q) begin
      sw_cnt_d = '0;
    end else if (sw_cnt_q != CNT_MAX) begin
      sw_cnt_d = sw_cnt_q + CNT_W'(1);
    end
    sw_stable_d = (sw_cnt_d == CNT_MAX);
    sw_deb_d    = sw_stable_d ? sw_now : sw_deb_q;
  end

  // Strobe arbitration: Clear always wins and discards any Enter, pending or new.
  always_comb begin
    pending_d     = pending_q;
    enter_pulse_d = 1'b0;
    clear_pulse_d = 1'b0;
    if (clear_rise) begin
      clear_pulse_d = 1'b1;
      pending_d     = 1'b0;
    end else if (enter_rise || pending_q) begin
      if (sw_stable_q) begin
        enter_pulse_d = 1'b1;
        pending_d     = 1'b0;
      end else begin
        pending_d = 1'b1;
      end
    end
    sw_out_d = enter_pulse_d ? sw_deb_q : sw_out_q;
    busy_d   = enter_level | clear_level | pending_d;
  end

  always_ff @(posedge clock or negedge Reset_n) begin
    if (!Reset_n) begin
      sw_sync_q     <= '0;
      sw_last_q     <= '0;
      sw_cnt_q      <= '0;
      sw_stable_q   <= 1'b0;
      sw_deb_q      <= '0;
      pending_q     <= 1'b0;
      enter_pulse_q <= 1'b0;
      clear_pulse_q <= 1'b0;
      sw_out_q      <= '0;
      busy_q        <= 1'b0;
    end else begin
      sw_sync_q     <= sw_sync_d;
      sw_last_q     <= sw_last_d;
      sw_cnt_q      <= sw_cnt_d;
      sw_stable_q   <= sw_stable_d;
      sw_deb_q      <= sw_deb_d;
      pending_q     <= pending_d;
      enter_pulse_q <= enter_pulse_d;
      clear_pulse_q <= clear_pulse_d;
      sw_out_q      <= sw_out_d;
      busy_q        <= busy_d;
    end
  end

  assign EnterPulse    = enter_pulse_q;
  assign ClearPulse    = clear_pulse_q;
  assign SwitchsOut    = sw_out_q;
  assign SwitchsStable = sw_stable_q;
  assign BusyLed       = busy_q;

endmodule
